// File: rtl/mpu_pkg.sv
// Shared MPU constants, element addressing and loader state encoding.
// Used by the matrix loader, the adder and the benches.
package mpu_pkg;

    localparam int DIM      = 5;
    localparam int ELEM_W   = 8;
    localparam int MAT_W    = ELEM_W * DIM * DIM;
    localparam int CNT_W    = 5;
    localparam int LAST_CNT = DIM * DIM - 1;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } loader_state_e;

    // Bit offset of element (i,j) in the flat column-major matrix vector.
    function automatic int elem_lsb(input int i, input int j);
        return ELEM_W * (i + DIM * j);
    endfunction

endpackage

// File: rtl/mpu_matrix_collector.sv
// One flat DIM x DIM matrix register; writes a single element per cycle
// at stream index idx. Cleared only by reset.
module mpu_matrix_collector
    import mpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [CNT_W-1:0]  idx,
    input  logic [ELEM_W-1:0] data,
    output logic [MAT_W-1:0]  mat
);

    // Stream index k = i + DIM*j maps straight onto element (k,0) offsets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat <= '0;
        end else if (we) begin
            mat[elem_lsb(int'(idx), 0) +: ELEM_W] <= data;
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Collects a byte stream into matrix A then matrix B and presents the pair.
// Optional framing check via in_last/err when MPU_LOADER_LAST_CHECK_EN is defined.
module mpu_matrix_loader
    import mpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
`ifdef MPU_LOADER_LAST_CHECK_EN
    input  logic              in_last,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MAT_W-1:0]  matrix_a,
    output logic [MAT_W-1:0]  matrix_b,
`ifdef MPU_LOADER_LAST_CHECK_EN
    output logic              err,
`endif
    output loader_state_e     dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid, once raised, holds its payload stable until that edge.
    loader_state_e    state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             we_a, we_b;
    logic             accept;
    logic             out_valid_q;
`ifdef MPU_LOADER_LAST_CHECK_EN
    logic             frame_err;
    logic             err_q;
`endif

    assign in_ready  = (state != HOLD);
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD_A;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            out_valid_q <= (state_d == HOLD);
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we_a    = 1'b0;
        we_b    = 1'b0;
`ifdef MPU_LOADER_LAST_CHECK_EN
        frame_err = 1'b0;
`endif
        if (clear) begin
            state_d = LOAD_A;
            cnt_d   = '0;
        end else begin
            unique case (state)
                LOAD_A: begin
                    if (accept) begin
`ifdef MPU_LOADER_LAST_CHECK_EN
                        if (in_last) begin
                            frame_err = 1'b1;
                            cnt_d     = '0;
                        end else
`endif
                        begin
                            we_a = 1'b1;
                            if (cnt == CNT_W'(LAST_CNT)) begin
                                state_d = LOAD_B;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt + 1'b1;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
`ifdef MPU_LOADER_LAST_CHECK_EN
                        // in_last must coincide exactly with the final B element.
                        if (in_last != (cnt == CNT_W'(LAST_CNT))) begin
                            frame_err = 1'b1;
                            state_d   = LOAD_A;
                            cnt_d     = '0;
                        end else
`endif
                        begin
                            we_b = 1'b1;
                            if (cnt == CNT_W'(LAST_CNT)) begin
                                state_d = HOLD;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt + 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_valid_q && out_ready) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef MPU_LOADER_LAST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (frame_err) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

    mpu_matrix_collector u_coll_a (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_a),
        .idx   (cnt),
        .data  (in_data),
        .mat   (matrix_a)
    );

    mpu_matrix_collector u_coll_b (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_b),
        .idx   (cnt),
        .data  (in_data),
        .mat   (matrix_b)
    );

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader with a scoreboard of expected matrix pairs.
// Define MPU_LOADER_LAST_CHECK_EN to also exercise the framing check.
module tb_mpu_matrix_loader;
    import mpu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;
    logic              in_last_s;
    logic              out_valid;
    logic              out_ready;
    logic [MAT_W-1:0]  matrix_a;
    logic [MAT_W-1:0]  matrix_b;
    logic              err;
    loader_state_e     dbg_state;

    int checks = 0;
    int errors = 0;
    int acc_count = 0;

    // Reference model state
    logic [MAT_W-1:0] exp_q[$];
    logic [MAT_W-1:0] ma, mb;
    int               mphase, mcnt;
    logic             err_exp;

    mpu_matrix_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef MPU_LOADER_LAST_CHECK_EN
        .in_last   (in_last_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
`ifdef MPU_LOADER_LAST_CHECK_EN
        .err       (err),
`endif
        .dbg_state (dbg_state)
    );

`ifndef MPU_LOADER_LAST_CHECK_EN
    assign err = 1'b0;
`endif

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_count <= acc_count + 1;
    end

    task automatic chk(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma = '0;
        mb = '0;
        mphase = 0;
        mcnt = 0;
        err_exp = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_clear();
        mphase = 0;
        mcnt = 0;
    endtask

    task automatic model_accept(input logic [7:0] d, input logic last);
`ifdef MPU_LOADER_LAST_CHECK_EN
        if (last != (mphase == 1 && mcnt == 24)) begin
            err_exp = 1'b1;
            mphase = 0;
            mcnt = 0;
            return;
        end
`endif
        if (mphase == 0) ma[8*mcnt +: 8] = d;
        else             mb[8*mcnt +: 8] = d;
        if (mcnt == 24) begin
            if (mphase == 0) begin
                mphase = 1;
            end else begin
                exp_q.push_back(ma);
                exp_q.push_back(mb);
                mphase = 0;
            end
            mcnt = 0;
        end else begin
            mcnt++;
        end
    endtask

    // driver tasks
    task automatic push_byte(input logic [7:0] d, input logic last);
        int w;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_last_s = last;
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) chk("push_timeout", {{(MAT_W-1){1'b0}}, in_ready}, 1);
        @(posedge clk);
        model_accept(d, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            in_last_s = 1'b0;
        end
    endtask

    // mode 0: A = 1..25, B = 25..1; mode 1: every byte 8'hA5
    task automatic stream_bytes(input int mode, input int from, input int to, input bit gaps, input int last_at);
        logic [7:0] d;
        for (int n = from; n < to; n++) begin
            if (mode == 0) d = (n < 25) ? 8'(n + 1) : 8'(50 - n);
            else           d = 8'hA5;
            push_byte(d, n == last_at);
            if (gaps) idle(1);
        end
    endtask

    task automatic stream_pair(input int mode, input bit gaps);
        stream_bytes(mode, 0, 50, gaps, 49);
    endtask

    // scoreboard pop/compare
    task automatic pop_check(input string tag);
        logic [MAT_W-1:0] ea, eb;
        if (exp_q.size() < 2) begin
            chk({tag, "_sb_empty"}, MAT_W'(exp_q.size()), 2);
        end else begin
            ea = exp_q.pop_front();
            eb = exp_q.pop_front();
            chk({tag, "_a"}, matrix_a, ea);
            chk({tag, "_b"}, matrix_b, eb);
        end
    endtask

    task automatic check_pair(input string tag);
        int w;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        pop_check(tag);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [MAT_W-1:0] ea, eb;
        logic             sum_ok;
        int               base;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last_s = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_a", matrix_a, '0);
        chk("rst_b", matrix_b, '0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_state", dbg_state, LOAD_A);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // Test 1: basic pair, out_ready high
        out_ready = 1'b1;
        stream_bytes(0, 0, 49, 0, 49);
        idle(1);
        chk("t1_pre_valid", out_valid, 0);
        push_byte(8'd1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_latency", out_valid, 1);
        chk("t1_in_ready", in_ready, 0);
        chk("t1_a_first", matrix_a[7:0], 8'd1);
        chk("t1_a_last", matrix_a[199:192], 8'd25);
        chk("t1_b_first", matrix_b[7:0], 8'd25);
        sum_ok = 1'b1;
        for (int k = 0; k < 25; k++)
            if (9'(matrix_a[8*k +: 8]) + 9'(matrix_b[8*k +: 8]) != 9'd26) sum_ok = 1'b0;
        chk("t1_add26", sum_ok, 1);
        pop_check("t1");
        @(negedge clk);
        chk("t1_consumed", out_valid, 0);
        chk("t1_ready_back", in_ready, 1);
        out_ready = 1'b0;

        // Test 2: backpressure for 10 cycles
        stream_pair(0, 0);
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_valid = 1'b1;
                in_data  = 8'hFF;
            end
            chk("t2_in_ready", in_ready, 0);
            chk("t2_out_valid", out_valid, 1);
            chk("t2_hold_a", matrix_a, ea);
            chk("t2_hold_b", matrix_b, eb);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t2_release_valid", out_valid, 0);
        chk("t2_release_ready", in_ready, 1);
        chk("t2_release_state", dbg_state, LOAD_A);

        // Test 3: in_valid toggling
        base = acc_count;
        stream_pair(0, 1);
        check_pair("t3");
        chk("t3_accepts", MAT_W'(acc_count - base), 50);
        consume();

        // Test 4: clear mid LOAD_B then A5 stream
        stream_bytes(0, 0, 37, 0, 49);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        chk("t4_pre_state", dbg_state, LOAD_B);
        @(posedge clk);
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        chk("t4_post_state", dbg_state, LOAD_A);
        chk("t4_no_pair", MAT_W'(exp_q.size()), 0);
        stream_pair(1, 0);
        check_pair("t4");
        chk("t4_all_a5_a", matrix_a, {25{8'hA5}});
        chk("t4_all_a5_b", matrix_b, {25{8'hA5}});
        consume();

        // Test 5: async reset mid LOAD_A
        stream_bytes(0, 0, 7, 0, 49);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_a", matrix_a, '0);
        chk("t5_rst_b", matrix_b, '0);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_state", dbg_state, LOAD_A);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", in_ready, 1);
        stream_pair(0, 0);
        check_pair("t5");
        consume();

`ifdef MPU_LOADER_LAST_CHECK_EN
        // Test 6: early in_last on byte 30
        chk("t6_err_clean", err, 0);
        stream_bytes(0, 0, 30, 0, 29);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_err_set", err, err_exp);
        chk("t6_restart", dbg_state, LOAD_A);
        stream_pair(0, 0);
        check_pair("t6");
        chk("t6_err_sticky", err, 1);
        consume();
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
